synapse_current_gen: RTL and testbench
======================================

# synapse_current_gen

Upstream stage of `LIFNeuron`: converts `N_INPUTS` presynaptic spike lines into the 8-bit synaptic current `Isyn` the neuron integrates. Each input has a programmable 8-bit weight, loaded through a valid/ready config port. Per cycle, the weights of the firing inputs are summed and added to a leaky current register (exponential decay by right shift), saturating at 255. The register drives the neuron's `Isyn` directly.

## Interface
- `N_INPUTS`, 4: number of presynaptic spike lines, 2..16.
- `DECAY_SHIFT`, 2: current decay per cycle is `I >> DECAY_SHIFT`, 1..7.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-high (asserted = 1) despite the name, matching the neuron.
- `pre_spike`  in  N_INPUTS  presynaptic spike pulses; bit i high = spike on input i this cycle.
- `cfg_valid`  in  1  weight-write request.
- `cfg_addr`  in  clog2(N_INPUTS)  weight index; out-of-range index = write dropped, still handshaked.
- `cfg_data`  in  8  weight value.
- `cfg_ready`  out  1  write accepted when `cfg_valid & cfg_ready`.
- `isyn`  out  8  synaptic current to neuron `Isyn`.
- `sat`  out  1  one-cycle pulse: current update clipped at 255.
- `spike_events`  out  16  count of cycles with at least one `pre_spike` bit set; wraps.

## Operation
- Reset: all weights 0, `isyn` 0, `sat` 0, `spike_events` 0, `cfg_ready` 0. The sum register (stage 1) is also 0.
- Config FSM states:
  - READY: `cfg_ready` = 1. A handshake writes `weight[cfg_addr] <= cfg_data` and moves to HOLD.
  - HOLD: `cfg_ready` = 0 for exactly one cycle, then back to READY.
  - The first cycle after reset release is RESET_WAIT (`cfg_ready` = 0), then READY.
- Stage 1 (sum):
  - `S <= Σ weight[i]` over the set bits of `pre_spike`, width 8+clog2(N_INPUTS), unsigned, no truncation.
  - It uses weights as they were before the current edge: a write and a spike on the same edge means the spike sees the old weight.
- Stage 2 (current): `D = I >> DECAY_SHIFT`, `T = I − D + S`.
  - If `S == 0` and `I < 2**DECAY_SHIFT`: `I <= 0`. Floor flush, so the current never sticks above zero.
  - Else if `T > 255`: `I <= 255` and `sat` = 1 for that cycle.
  - Else: `I <= T`.
- `spike_events` increments when `|pre_spike`, registered together with stage 1. It wraps 0xFFFF → 0.
- No back-pressure on spikes: every cycle's `pre_spike` is consumed.

## Timing
- Latency: `pre_spike` sampled at edge k; `S` updated at k; `isyn` reflects it after edge k+1 (2-cycle latency). `spike_events` updates after edge k.
- Weight write at edge k affects spikes sampled at edge k+1 onward.
- Config throughput: one write per 2 cycles.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge. In-flight `S` is discarded and a pending handshake is lost.
- `sat` is combinationally derived from registered state, so it is registered alongside `I`. It is never high during reset.

## Structure
- Shared package `snn_pkg`:
  - `ISYN_W = 8`, `WEIGHT_W = 8`.
  - Function `sat_u8(x)` for clipping.
  - Typedef `isyn_t` for the 8-bit current; `LIFNeuron` reuses it.
- Sub-module `synapse_weight_bank`:
  - Contains the weight register array, the config FSM and the handshake.
  - Exports the flat weight vector.
- Top module: sum tree, current register, event counter.

## Test plan
- Reset: hold `rst_n` = 1 with spikes toggling → `isyn` = 0, `cfg_ready` = 0, `spike_events` = 0. After release, `cfg_ready` goes to 1 after one cycle.
- Weights {10, 20, 30, 40}, `DECAY_SHIFT` = 2:
  - Single pulse `pre_spike` = 4'b0101 → `isyn` = 40 two cycles later.
  - Decay sequence: 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, then 0 via floor flush.
- Saturation: weights all 100, `pre_spike` = 4'b1111 held → `isyn` = 255 with `sat` pulsing every cycle. Release spikes → `sat` = 0 and decay starts from 255 (next value 192).
- Write/spike collision: `weight[1]` = 5, then write 50 on the same edge a spike on input 1 is sampled → that spike contributes 5 and the next one contributes 50. `cfg_ready` low for exactly one cycle after the write.
- Reset mid-accumulation: `isyn` = 120, assert `rst_n` asynchronously between edges → `isyn` = 0 immediately and weights read back 0.
- Counter wrap: preload by 65535 spike cycles (or force) → next spike cycle gives `spike_events` = 0. Cycles with `pre_spike` = 0 do not count.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-neuron datapath.
// The synaptic current type is shared with the downstream LIF neuron.
`timescale 1ns/1ps
package snn_pkg;

    localparam int ISYN_W   = 8;
    localparam int WEIGHT_W = 8;

    typedef logic [ISYN_W-1:0] isyn_t;

    typedef enum logic [1:0] {
        CFG_RESET_WAIT,
        CFG_READY,
        CFG_HOLD
    } cfg_state_t;

    function automatic isyn_t sat_u8(input logic [15:0] x);
        return (x > 16'd255) ? isyn_t'(8'hFF) : isyn_t'(x[7:0]);
    endfunction

endpackage

// File: rtl/synapse_weight_bank.sv
// Programmable synapse weights behind a valid/ready write port.
// Each accepted write is followed by one not-ready cycle.
`timescale 1ns/1ps
module synapse_weight_bank
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int AW       = $clog2(N_INPUTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    input  logic [AW-1:0]                cfg_addr,
    input  logic [WEIGHT_W-1:0]          cfg_data,
    output logic                         cfg_ready,
    output logic [N_INPUTS*WEIGHT_W-1:0] weights
);

    cfg_state_t          state;
    logic [WEIGHT_W-1:0] w [N_INPUTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CFG_RESET_WAIT;
            cfg_ready <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) begin
                w[i] <= '0;
            end
        end else begin
            unique case (state)
                CFG_RESET_WAIT: begin
                    state     <= CFG_READY;
                    cfg_ready <= 1'b1;
                end
                CFG_READY: begin
                    if (cfg_valid) begin
                        // Addresses with no matching entry are silently dropped
                        for (int i = 0; i < N_INPUTS; i++) begin
                            if (cfg_addr == AW'(i)) begin
                                w[i] <= cfg_data;
                            end
                        end
                        state     <= CFG_HOLD;
                        cfg_ready <= 1'b0;
                    end
                end
                CFG_HOLD: begin
                    state     <= CFG_READY;
                    cfg_ready <= 1'b1;
                end
                default: begin
                    state     <= CFG_RESET_WAIT;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_INPUTS; g++) begin : g_flat
        assign weights[g*WEIGHT_W +: WEIGHT_W] = w[g];
    end

endmodule

// File: rtl/synapse_current_gen.sv
// Presynaptic spikes to leaky, saturating synaptic current for the LIF neuron.
// Stage 1 sums firing weights, stage 2 decays and accumulates the current.
`timescale 1ns/1ps
module synapse_current_gen
    import snn_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_INPUTS-1:0]         pre_spike,
    input  logic                        cfg_valid,
    input  logic [$clog2(N_INPUTS)-1:0] cfg_addr,
    input  logic [WEIGHT_W-1:0]         cfg_data,
    output logic                        cfg_ready,
    output isyn_t                       isyn,
    output logic                        sat,
    output logic [15:0]                 spike_events
);

    localparam int AW = $clog2(N_INPUTS);
    localparam int SW = WEIGHT_W + AW;
    localparam int TW = SW + 1;

    logic [N_INPUTS*WEIGHT_W-1:0] weights;
    logic [SW-1:0]                sum;
    logic [SW-1:0]                s_q;
    isyn_t                        i_q;
    isyn_t                        d;
    logic [TW-1:0]                t;
    logic                         flush;

    // rst_n is active-high to match the neuron
    synapse_weight_bank #(
        .N_INPUTS (N_INPUTS)
    ) u_bank (
        .clk       (clk),
        .rst       (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .weights   (weights)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (pre_spike[i]) begin
                sum = sum + SW'(weights[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

    always_comb begin
        d     = i_q >> DECAY_SHIFT;
        t     = TW'(i_q) - TW'(d) + TW'(s_q);
        flush = (s_q == '0) && (i_q < isyn_t'(1 << DECAY_SHIFT));
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s_q          <= '0;
            i_q          <= '0;
            sat          <= 1'b0;
            spike_events <= '0;
        end else begin
            s_q <= sum;
            if (|pre_spike) begin
                spike_events <= spike_events + 16'd1;
            end
            // Shift decay alone stalls below 2**DECAY_SHIFT
            if (flush) begin
                i_q <= '0;
                sat <= 1'b0;
            end else begin
                i_q <= sat_u8(16'(t));
                sat <= (t > TW'(255));
            end
        end
    end

    assign isyn = i_q;

endmodule

// File: tb/tb_synapse_current_gen.sv
// Directed self-checking bench for synapse_current_gen.
`timescale 1ns/1ps
module tb_synapse_current_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pre_spike;
    logic        cfg_valid;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic [7:0]  isyn;
    logic        sat;
    logic [15:0] spike_events;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_ev = '0;

    always #5 clk = ~clk;

    synapse_current_gen #(
        .N_INPUTS    (4),
        .DECAY_SHIFT (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pre_spike    (pre_spike),
        .cfg_valid    (cfg_valid),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ready    (cfg_ready),
        .isyn         (isyn),
        .sat          (sat),
        .spike_events (spike_events)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic spike_cycle(input logic [3:0] p);
        pre_spike = p;
        tick();
        if (p != 4'd0) exp_ev = exp_ev + 16'd1;
        pre_spike = '0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout got=%0b want=1", cfg_ready);
        end
    endtask

    task automatic write_weight(input logic [1:0] a, input logic [7:0] v);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = v;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            pre_spike = (k % 2 == 1) ? 4'hF : 4'h5;
            tick();
        end
        pre_spike = '0;
        checks++;
        if (isyn !== 8'd0) begin
            errors++;
            $display("FAIL rst_isyn got=%0d want=0", isyn);
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got=%0b want=0", cfg_ready);
        end
        checks++;
        if (spike_events !== 16'd0) begin
            errors++;
            $display("FAIL rst_events got=%0d want=0", spike_events);
        end
        checks++;
        if (sat !== 1'b0) begin
            errors++;
            $display("FAIL rst_sat got=%0b want=0", sat);
        end
        rst_n = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_ready got=%0b want=0", cfg_ready);
        end
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got=%0b want=1", cfg_ready);
        end
    endtask

    task automatic test_pulse_decay();
        int exp_seq [12] = '{30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 0};
        write_weight(2'd0, 8'd10);
        write_weight(2'd1, 8'd20);
        write_weight(2'd2, 8'd30);
        write_weight(2'd3, 8'd40);
        spike_cycle(4'b0101);
        checks++;
        if (spike_events !== exp_ev) begin
            errors++;
            $display("FAIL pulse_events got=%0d want=%0d", spike_events, exp_ev);
        end
        checks++;
        if (isyn !== 8'd0) begin
            errors++;
            $display("FAIL pulse_latency got=%0d want=0", isyn);
        end
        tick();
        checks++;
        if (isyn !== 8'd40) begin
            errors++;
            $display("FAIL pulse_isyn got=%0d want=40", isyn);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if (isyn !== 8'(exp_seq[k])) begin
                errors++;
                $display("FAIL decay_%0d got=%0d want=%0d", k, isyn, exp_seq[k]);
            end
        end
    endtask

    task automatic test_saturation();
        for (int a = 0; a < 4; a++) write_weight(2'(a), 8'd100);
        pre_spike = 4'hF;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_ev = exp_ev + 16'd1;
            if (c >= 2) begin
                checks++;
                if (isyn !== 8'd255 || sat !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_hold_%0d got=%0d/%0b want=255/1", c, isyn, sat);
                end
            end
        end
        pre_spike = '0;
        tick();
        checks++;
        if (isyn !== 8'd255 || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_tail got=%0d/%0b want=255/1", isyn, sat);
        end
        tick();
        checks++;
        if (isyn !== 8'd192 || sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_release got=%0d/%0b want=192/0", isyn, sat);
        end
        repeat (25) tick();
        checks++;
        if (isyn !== 8'd0) begin
            errors++;
            $display("FAIL sat_drain got=%0d want=0", isyn);
        end
        checks++;
        if (spike_events !== exp_ev) begin
            errors++;
            $display("FAIL sat_events got=%0d want=%0d", spike_events, exp_ev);
        end
    endtask

    task automatic test_collision();
        write_weight(2'd0, 8'd0);
        write_weight(2'd2, 8'd0);
        write_weight(2'd3, 8'd0);
        write_weight(2'd1, 8'd5);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_addr  = 2'd1;
        cfg_data  = 8'd50;
        pre_spike = 4'b0010;
        tick();
        exp_ev = exp_ev + 16'd1;
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_hold got=%0b want=0", cfg_ready);
        end
        tick();
        exp_ev = exp_ev + 16'd1;
        pre_spike = '0;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_ready got=%0b want=1", cfg_ready);
        end
        checks++;
        if (isyn !== 8'd5) begin
            errors++;
            $display("FAIL coll_old_weight got=%0d want=5", isyn);
        end
        tick();
        checks++;
        if (isyn !== 8'd54) begin
            errors++;
            $display("FAIL coll_new_weight got=%0d want=54", isyn);
        end
        checks++;
        if (spike_events !== exp_ev) begin
            errors++;
            $display("FAIL coll_events got=%0d want=%0d", spike_events, exp_ev);
        end
    endtask

    task automatic test_reset_mid();
        repeat (40) tick();
        write_weight(2'd0, 8'd120);
        spike_cycle(4'b0001);
        tick();
        checks++;
        if (isyn !== 8'd120) begin
            errors++;
            $display("FAIL mid_preload got=%0d want=120", isyn);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (isyn !== 8'd0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL mid_async got=%0d/%0b want=0/0", isyn, sat);
        end
        checks++;
        if (spike_events !== 16'd0 || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_state got=%0d/%0b want=0/0", spike_events, cfg_ready);
        end
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        exp_ev = '0;
        tick();
        spike_cycle(4'hF);
        tick();
        checks++;
        if (isyn !== 8'd0) begin
            errors++;
            $display("FAIL mid_weights_cleared got=%0d want=0", isyn);
        end
        checks++;
        if (spike_events !== 16'd1) begin
            errors++;
            $display("FAIL mid_events got=%0d want=1", spike_events);
        end
    endtask

    task automatic test_counter_wrap();
        repeat (3) tick();
        checks++;
        if (spike_events !== exp_ev) begin
            errors++;
            $display("FAIL wrap_idle got=%0d want=%0d", spike_events, exp_ev);
        end
        pre_spike = 4'b1000;
        repeat (65534) @(posedge clk);
        #1;
        pre_spike = '0;
        exp_ev = exp_ev + 16'd65534;
        checks++;
        if (spike_events !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_full got=%0d want=65535", spike_events);
        end
        tick();
        checks++;
        if (spike_events !== exp_ev) begin
            errors++;
            $display("FAIL wrap_quiet got=%0d want=%0d", spike_events, exp_ev);
        end
        spike_cycle(4'b0010);
        checks++;
        if (spike_events !== 16'd0) begin
            errors++;
            $display("FAIL wrap_zero got=%0d want=0", spike_events);
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        pre_spike = '0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        test_reset();
        test_pulse_decay();
        test_saturation();
        test_collision();
        test_reset_mid();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
